sr_latch_driver: RTL and testbench

//  Clocked controller that drives the active-low S/R inputs of a cross-coupled NAND SR latch.

---
 rtl/sr_latch_driver_if.sv | 24 ++
 rtl/sr_latch_driver.sv | 137 +++++++++++++
 tb/tb_sr_latch_driver.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_driver_if.sv
// Control and latch-side signals of the SR latch driver, grouped as one bundle.
// The master side issues requests and returns the latch q; the slave side is the driver.
interface sr_latch_driver_if;
    logic set_req;
    logic clr_req;
    logic ready;
    logic s_n;
    logic r_n;
    logic q_fb;
    logic done;
    logic mismatch;
    logic illegal;
    logic q_exp;

    modport master (
        output set_req, clr_req, q_fb,
        input  ready, s_n, r_n, done, mismatch, illegal, q_exp
    );

    modport slave (
        input  set_req, clr_req, q_fb,
        output ready, s_n, r_n, done, mismatch, illegal, q_exp
    );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives active-low S/R of a NAND latch with fixed-width pulses, a recovery gap and a synced q check.
// Latency: accept -> done after PULSE_W+GAP_W cycles; requests while not ready are dropped, never queued.
module sr_latch_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 3,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_latch_driver_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SET_P,
        ST_CLR_P,
        ST_GAP
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tgt_q, tgt_d;
    logic               s_n_q, s_n_d;
    logic               r_n_q, r_n_d;
    logic               done_q, done_d;
    logic               mis_q, mis_d;
    logic               ill_q, ill_d;
    logic               qexp_q, qexp_d;
    logic               sync1_q, sync2_q;
    logic               req_one, req_both;

    assign req_one  = bus.set_req ^ bus.clr_req;
    assign req_both = bus.set_req & bus.clr_req;

    // q_fb is asynchronous to clk; two flops before anything looks at it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.q_fb;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            tgt_q   <= 1'b0;
            s_n_q   <= 1'b1;
            r_n_q   <= 1'b1;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            ill_q   <= 1'b0;
            qexp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            s_n_q   <= s_n_d;
            r_n_q   <= r_n_d;
            done_q  <= done_d;
            mis_q   <= mis_d;
            ill_q   <= ill_d;
            qexp_q  <= qexp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        ill_d   = 1'b0;
        mis_d   = mis_q;
        qexp_d  = qexp_q;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_CLR_P;
                cnt_d   = PULSE_LD;
                tgt_d   = 1'b0;
            end
            ST_IDLE: begin
                if (req_one) begin
                    state_d = bus.set_req ? ST_SET_P : ST_CLR_P;
                    cnt_d   = PULSE_LD;
                    tgt_d   = bus.set_req;
                    mis_d   = 1'b0;
                end else if (req_both) begin
                    ill_d   = 1'b1;
                end
            end
            ST_SET_P, ST_CLR_P: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                // last gap cycle: the synced latch has had at least GAP_W cycles to settle
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    qexp_d  = tgt_q;
                    mis_d   = (sync2_q != tgt_q);
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // derived from the single next state, so s_n and r_n can never both be low
        s_n_d = (state_d != ST_SET_P);
        r_n_d = (state_d != ST_CLR_P);
    end

    assign bus.ready    = (state_q == ST_IDLE);
    assign bus.s_n      = s_n_q;
    assign bus.r_n      = r_n_q;
    assign bus.done     = done_q;
    assign bus.mismatch = mis_q;
    assign bus.illegal  = ill_q;
    assign bus.q_exp    = qexp_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver driving a gate-delay NAND latch model.
// Cycle N is the period after rising edge N (cyc counts edges); done of an accept at edge k lands in cycle k+7.
module tb_sr_latch_driver;

    localparam int PW = 4;
    localparam int GW = 3;

    typedef struct {
        int   cyc;
        logic q_exp;
        logic mis;
        logic qfb;
    } done_t;

    typedef struct {
        bit is_set;
        int width;
    } pulse_t;

    typedef struct {
        int   cyc;
        logic q_exp;
    } ill_t;

    logic clk = 1'b0;
    logic rst_n;
    logic force_lo;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic model_qexp = 1'b0;

    done_t  done_sb[$];
    pulse_t pulse_sb[$];
    ill_t   ill_sb[$];

    sr_latch_driver_if bus ();

    sr_latch_driver #(.PULSE_W(PW), .GAP_W(GW), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // cross-coupled NAND latch, 1ns per gate, starting in the stable q=0 state
    logic lq  = 1'b0;
    logic lqb = 1'b1;
    always @(bus.s_n or lqb) lq  <= #1 ~(bus.s_n & lqb);
    always @(bus.r_n or lq)  lqb <= #1 ~(bus.r_n & lq);
    assign bus.q_fb = lq & ~force_lo;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic pulse_end(input bit is_set, input int width);
        pulse_t e;
        checks++;
        if (pulse_sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: %s low %0d cycles, none expected (cycle %0d)",
                     is_set ? "s_n" : "r_n", width, cyc);
        end else begin
            e = pulse_sb.pop_front();
            if (e.is_set != is_set || e.width != width) begin
                errors++;
                $display("FAIL pulse: got %s width %0d expected %s width %0d (cycle %0d)",
                         is_set ? "s_n" : "r_n", width, e.is_set ? "s_n" : "r_n", e.width, cyc);
            end
        end
    endtask

    // monitor: invariant every cycle, pops scoreboard on pulse ends, done and illegal
    int s_run = 0;
    int r_run = 0;
    always @(negedge clk) begin
        done_t e;
        ill_t  ie;
        checks++;
        if (!(bus.s_n | bus.r_n)) begin
            errors++;
            $display("FAIL invariant: s_n=%0b r_n=%0b expected s_n|r_n=1 (cycle %0d)", bus.s_n, bus.r_n, cyc);
        end
        if (!rst_n) begin
            s_run = 0;
            r_run = 0;
        end else begin
            if (!bus.s_n) s_run++;
            else if (s_run != 0) begin pulse_end(1'b1, s_run); s_run = 0; end
            if (!bus.r_n) r_run++;
            else if (r_run != 0) begin pulse_end(1'b0, r_run); r_run = 0; end

            if (bus.done) begin
                checks++;
                if (done_sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: done=1 with none expected (cycle %0d)", cyc);
                end else begin
                    e = done_sb.pop_front();
                    if (cyc != e.cyc || bus.ready !== 1'b1 || bus.q_exp !== e.q_exp ||
                        bus.mismatch !== e.mis || bus.q_fb !== e.qfb) begin
                        errors++;
                        $display("FAIL done: got cyc=%0d ready=%0b q_exp=%0b mismatch=%0b q_fb=%0b expected cyc=%0d ready=1 q_exp=%0b mismatch=%0b q_fb=%0b",
                                 cyc, bus.ready, bus.q_exp, bus.mismatch, bus.q_fb,
                                 e.cyc, e.q_exp, e.mis, e.qfb);
                    end
                end
            end

            if (bus.illegal) begin
                checks++;
                if (ill_sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_illegal: illegal=1 with none expected (cycle %0d)", cyc);
                end else begin
                    ie = ill_sb.pop_front();
                    if (cyc != ie.cyc || bus.ready !== 1'b1 || bus.q_exp !== ie.q_exp ||
                        bus.s_n !== 1'b1 || bus.r_n !== 1'b1) begin
                        errors++;
                        $display("FAIL illegal: got cyc=%0d ready=%0b q_exp=%0b s_n=%0b r_n=%0b expected cyc=%0d ready=1 q_exp=%0b s_n=1 r_n=1",
                                 cyc, bus.ready, bus.q_exp, bus.s_n, bus.r_n, ie.cyc, ie.q_exp);
                    end
                end
            end
        end
    end

    // returns at a falling edge with ready=1, or reports a timeout
    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL ready_timeout: ready=%0b expected 1 within 40 cycles (cycle %0d)", bus.ready, cyc);
    endtask

    // one-cycle request; when track is set the expected pulse/done/illegal go to the scoreboard
    task automatic request(input logic s, input logic c, input bit track,
                           input logic exp_mis, input logic exp_qfb);
        int k;
        wait_ready();
        bus.set_req = s;
        bus.clr_req = c;
        @(posedge clk);
        #1;
        k = cyc;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        if (track) begin
            if (s ^ c) begin
                pulse_sb.push_back('{is_set: s, width: PW});
                done_sb.push_back('{cyc: k + PW + GW, q_exp: s, mis: exp_mis, qfb: exp_qfb});
                model_qexp = s;
            end else if (s & c) begin
                ill_sb.push_back('{cyc: k, q_exp: model_qexp});
            end
        end
    endtask

    task automatic release_reset();
        int r;
        rst_n = 1'b1;
        r = cyc;
        pulse_sb.push_back('{is_set: 1'b0, width: PW});
        done_sb.push_back('{cyc: r + 1 + PW + GW, q_exp: 1'b0, mis: 1'b0, qfb: 1'b0});
        model_qexp = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish by 20000ns");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        force_lo    = 1'b0;
        bus.set_req = 1'b0;
        bus.clr_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_n", int'(bus.s_n), 1);
        chk("rst_r_n", int'(bus.r_n), 1);
        chk("rst_ready", int'(bus.ready), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_mismatch", int'(bus.mismatch), 0);
        chk("rst_illegal", int'(bus.illegal), 0);
        chk("rst_q_exp", int'(bus.q_exp), 0);

        // init clear after reset release
        release_reset();

        // plain set
        request(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

        // both requests: illegal pulse, nothing driven
        request(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // redundant set with requests thrown at it during the pulse and the gap
        request(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk); bus.clr_req = 1'b1;
        @(negedge clk); bus.clr_req = 1'b0; bus.set_req = 1'b1;
        @(negedge clk); bus.set_req = 1'b0;
        @(negedge clk); bus.clr_req = 1'b1;
        @(negedge clk); bus.clr_req = 1'b0;
        chk("ignored_ready_in_gap", int'(bus.ready), 0);

        // plain clear
        request(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

        // latch feedback held low across a set: mismatch at done, sticky in idle
        force_lo = 1'b1;
        request(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_ready();
        @(negedge clk);
        chk("mismatch_sticky", int'(bus.mismatch), 1);
        force_lo = 1'b0;

        // next accepted request clears mismatch in the cycle after acceptance
        request(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("mismatch_cleared", int'(bus.mismatch), 0);

        // reset in the middle of a set pulse
        request(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_s_n", int'(bus.s_n), 1);
        chk("midrst_r_n", int'(bus.r_n), 1);
        chk("midrst_ready", int'(bus.ready), 0);
        chk("midrst_q_exp", int'(bus.q_exp), 0);
        repeat (3) @(negedge clk);
        chk("midrst_latch_kept", int'(bus.q_fb), 1);
        release_reset();

        // normal operation after the reset-driven init clear
        request(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_ready();
        repeat (5) @(negedge clk);

        chk("done_sb_empty", done_sb.size(), 0);
        chk("pulse_sb_empty", pulse_sb.size(), 0);
        chk("ill_sb_empty", ill_sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
